top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameter D_width, default 32: data and modulus width.
REQ-002 Parameters BN = 16 (banks), MA = 512 (words per bank), degree = BN*MA = 8192, LOGN = 13, k = 2 (twiddle-base rows = k+3 = 5).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 modulus  input  D_width  prime q, quasi-static after reset; 2*degree divides q-1, q < 2^(D_width-1); reference value 167772161.
REQ-006 DONE  output  1  high when the transform is complete.

Function
REQ-007 The block shall compute an in-place forward negacyclic NTT of a[0..degree-1] mod q:
- Longa-Naehrig order: t = degree; for m = 1,2,4..degree/2, t = t/2.
- For each group i < m: S = psi^brv13(m+i).
- For each j in [2it, 2it+t-1]: U = a[j], V = S*a[j+t] mod q; a[j] = (U+V) mod q; a[j+t] = (U-V) mod q.
REQ-008 Element a[j] shall reside in bank j mod 16 at address j/16.
REQ-009 Hierarchy path memory_wrapper.gen_sram[b].sram.mem[addr] shall be that storage; benches preload and read it by backdoor.
REQ-010 Each bank shall be a dual-port 512 x D_width SRAM: synchronous write, 1-cycle read latency.
REQ-011 Twiddle storage TF_top.TF_gen.TF_base_array[0:k+2][0:14] and TF_top.TF_gen.TF_const_array[0:13] shall be D_width registers loaded by backdoor and never written by the design.
REQ-012 TF_base_array[0][b] holds psi^(2^b) mod q for b = 0..12. S = product of TF_base_array[0][b] over the set bits b of brv13(m+i), computed with one modular multiply per cycle; S = 1 when the exponent is 0. Rows 1..k+2 and TF_const_array are reserved and unused.
REQ-013 Modular multiply: full 2*D_width product, then mod q; add/sub shall use a single conditional correction (operands < q).
REQ-014 FSM states:
- WAIT: count LOAD_CYC = (k+3)+MA+4 cycles after reset release.
- TWID: build S, 13 cycles per group.
- READ: port A address of a[j], port B address of a[j+t].
- CALC: one cycle after read data returns.
- WRITE: both results written in the same cycle via ports A and B.
- NEXT: advance j; at group end go to TWID; at last stage go to FIN.
- FIN: terminal.
REQ-015 Same-bank pairs (t >= 16) shall use distinct addresses on ports A and B; a read never overlaps a pending write to the same word.
REQ-016 DONE shall assert on entry to FIN and stay high until reset; banks shall not be written in FIN.
REQ-017 No start/handshake input exists; one transform runs per reset.

Reset
REQ-018 rst low shall asynchronously set FSM = WAIT, counters = 0, DONE = 0.
REQ-019 rst low mid-transform shall abort the transform; SRAM contents are left as-is and TF registers are not cleared.
REQ-020 After rst returns high, the full sequence shall restart from WAIT.

Structure
REQ-021 A shared package shall hold D_width, BN, MA, degree, LOGN, k, LOAD_CYC and the FSM state enum.
REQ-022 Required submodules: memory_wrapper (generate gen_sram[0..15], instance sram, SRAM_DP_512) and TF_top containing TF_gen; control and butterfly logic stay in top.
REQ-023 mod_mul is the natural shared sub-module, used by both twiddle build and butterfly.

Verification
REQ-024 All-zero memory, q = 167772161 -> DONE rises; all 8192 words read 0.
REQ-025 a[0] = 1, others 0 -> every output word = 1.
REQ-026 a[1] = 1 -> out[j] = psi^(2*brv13(j)+1) mod q, compared against a software model.
REQ-027 Random input < q -> outputs match the Python model word-for-word, in bank-major dump order (bank 0 addresses 0..511 first).
REQ-028 Assert rst low during stage 5, then release -> DONE = 0 within 1 cycle; a full rerun after reload matches the golden output.
REQ-029 DONE asserts exactly once and stays high for 1000 further cycles; no SRAM writes occur after DONE.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and FSM state codes for the in-place negacyclic NTT engine.
package ntt_pkg;
  localparam int D_width  = 32;
  localparam int BN       = 16;
  localparam int MA       = 512;
  localparam int degree   = BN * MA;
  localparam int LOGN     = 13;
  localparam int k        = 2;
  localparam int LOAD_CYC = (k + 3) + MA + 4;

  localparam logic [2:0] ST_WAIT  = 3'd0;
  localparam logic [2:0] ST_TWID  = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_CALC  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;
  localparam logic [2:0] ST_FIN   = 3'd6;
endpackage

// File: rtl/SRAM_DP_512.sv
// Dual-port SRAM bank: synchronous write on each port, registered read (1-cycle latency).
module SRAM_DP_512 #(
  parameter int W     = 32,
  parameter int DEPTH = 512
)(
  input  logic                     clk,
  input  logic                     we_a,
  input  logic [$clog2(DEPTH)-1:0] addr_a,
  input  logic [W-1:0]             wd_a,
  output logic [W-1:0]             rd_a,
  input  logic                     we_b,
  input  logic [$clog2(DEPTH)-1:0] addr_b,
  input  logic [W-1:0]             wd_b,
  output logic [W-1:0]             rd_b
);
  logic [W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wd_a;
    if (we_b) mem[addr_b] <= wd_b;
    rd_a <= mem[addr_a];
    rd_b <= mem[addr_b];
  end
endmodule

// File: rtl/TF_top.sv
// Twiddle-base register file, filled externally; only row 0 (psi^(2^b)) is consumed.
module TF_gen
  import ntt_pkg::*;
#(
  parameter int W = 32
)(
  input  logic [3:0]   sel,
  output logic [W-1:0] base
);
  logic [W-1:0] TF_base_array  [0:k+2][0:14];
  logic [W-1:0] TF_const_array [0:13];

  assign base = TF_base_array[0][sel];
endmodule

module TF_top #(
  parameter int W = 32
)(
  input  logic [3:0]   sel,
  output logic [W-1:0] base
);
  TF_gen #(.W(W)) TF_gen (.sel(sel), .base(base));
endmodule

// File: rtl/memory_wrapper.sv
// Banked coefficient store: element j lives in bank j%BN at address j/BN.
module memory_wrapper #(
  parameter int W  = 32,
  parameter int BN = 16,
  parameter int MA = 512,
  parameter int IW = 13
)(
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] ja,
  input  logic [IW-1:0] jb,
  input  logic [W-1:0]  wd_a,
  input  logic [W-1:0]  wd_b,
  output logic [W-1:0]  rd_a,
  output logic [W-1:0]  rd_b
);
  localparam int BW = $clog2(BN);

  logic [BW-1:0]         bank_a, bank_b, bank_a_q, bank_b_q;
  logic [IW-BW-1:0]      addr_a, addr_b;
  logic [BN-1:0][W-1:0]  rda_all, rdb_all;

  assign bank_a = ja[BW-1:0];
  assign bank_b = jb[BW-1:0];
  assign addr_a = ja[IW-1:BW];
  assign addr_b = jb[IW-1:BW];

  // Bank selects follow the read data through the SRAM's output register.
  always_ff @(posedge clk) begin
    bank_a_q <= bank_a;
    bank_b_q <= bank_b;
  end

  for (genvar g = 0; g < BN; g++) begin : gen_sram
    SRAM_DP_512 #(.W(W), .DEPTH(MA)) sram (
      .clk    (clk),
      .we_a   (we && (bank_a == BW'(g))),
      .addr_a (addr_a),
      .wd_a   (wd_a),
      .rd_a   (rda_all[g]),
      .we_b   (we && (bank_b == BW'(g))),
      .addr_b (addr_b),
      .wd_b   (wd_b),
      .rd_b   (rdb_all[g])
    );
  end

  assign rd_a = rda_all[bank_a_q];
  assign rd_b = rdb_all[bank_b_q];
endmodule

// File: rtl/mod_mul.sv
// Combinational modular multiply: full double-width product reduced mod q.
module mod_mul #(
  parameter int W = 32
)(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  output logic [W-1:0] r
);
  logic [2*W-1:0] p;
  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign r = W'(p % {{W{1'b0}}, q});
endmodule

// File: rtl/top.sv
// In-place forward negacyclic NTT (Longa-Naehrig order) over banked dual-port SRAM.
module top
  import ntt_pkg::*;
#(
  parameter int D_width = ntt_pkg::D_width,
  parameter int BN      = ntt_pkg::BN,
  parameter int MA      = ntt_pkg::MA
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [D_width-1:0] modulus,
  output logic               DONE
);
  localparam int degree = BN * MA;
  localparam int LOGN   = $clog2(degree);
  localparam int LOAD   = (k + 3) + MA + 4;
  localparam logic [D_width-1:0] ONE = D_width'(1);
  typedef logic [LOGN-1:0] idx_t;

  logic [2:0]         state;
  logic [15:0]        wcnt;
  logic [3:0]         tcnt;
  idx_t               m, i, t, j, gstart;
  logic [D_width-1:0] S, res_a, res_b, rd_a, rd_b, base, mm_b, mm_r;
  logic [D_width-1:0] sum, diff, u_plus_v, u_minus_v;
  logic [15:0]        e_pad;
  logic               mem_we;

  function automatic idx_t brv(input idx_t x);
    idx_t r;
    r = '0;
    for (int b = 0; b < LOGN; b++) r[b] = x[LOGN-1-b];
    return r;
  endfunction

  assign e_pad = 16'(brv(m + i));

  TF_top #(.W(D_width)) TF_top (.sel(tcnt), .base(base));

  // One multiplier serves both the twiddle build (S *= base or 1) and V = S*a[j+t].
  assign mm_b = (state == ST_CALC) ? rd_b : (e_pad[tcnt] ? base : ONE);
  mod_mul #(.W(D_width)) mm (.a(S), .b(mm_b), .q(modulus), .r(mm_r));

  assign sum       = rd_a + mm_r;
  assign u_plus_v  = (sum >= modulus) ? sum - modulus : sum;
  assign diff      = rd_a - mm_r;
  assign u_minus_v = (rd_a < mm_r) ? diff + modulus : diff;

  assign mem_we = (state == ST_WRITE);

  memory_wrapper #(.W(D_width), .BN(BN), .MA(MA), .IW(LOGN)) memory_wrapper (
    .clk  (clk),
    .we   (mem_we),
    .ja   (j),
    .jb   (j + t),
    .wd_a (res_a),
    .wd_b (res_b),
    .rd_a (rd_a),
    .rd_b (rd_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_WAIT;
      wcnt   <= '0;
      tcnt   <= '0;
      m      <= '0;
      i      <= '0;
      t      <= '0;
      j      <= '0;
      gstart <= '0;
      S      <= '0;
      res_a  <= '0;
      res_b  <= '0;
      DONE   <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wcnt == 16'(LOAD - 1)) begin
            state  <= ST_TWID;
            m      <= idx_t'(1);
            t      <= idx_t'(degree / 2);
            i      <= '0;
            j      <= '0;
            gstart <= '0;
            S      <= ONE;
            tcnt   <= '0;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        ST_TWID: begin
          S <= mm_r;
          if (tcnt == 4'(LOGN - 1)) state <= ST_READ;
          else                      tcnt  <= tcnt + 4'd1;
        end
        ST_READ:  state <= ST_CALC;
        ST_CALC: begin
          res_a <= u_plus_v;
          res_b <= u_minus_v;
          state <= ST_WRITE;
        end
        ST_WRITE: state <= ST_NEXT;
        ST_NEXT: begin
          if (j == gstart + t - idx_t'(1)) begin
            if (i == m - idx_t'(1)) begin
              if (t == idx_t'(1)) begin
                state <= ST_FIN;
                DONE  <= 1'b1;
              end else begin
                m      <= m << 1;
                t      <= t >> 1;
                i      <= '0;
                gstart <= '0;
                j      <= '0;
                S      <= ONE;
                tcnt   <= '0;
                state  <= ST_TWID;
              end
            end else begin
              i      <= i + idx_t'(1);
              gstart <= gstart + (t << 1);
              j      <= gstart + (t << 1);
              S      <= ONE;
              tcnt   <= '0;
              state  <= ST_TWID;
            end
          end else begin
            j     <= j + idx_t'(1);
            state <= ST_READ;
          end
        end
        ST_FIN:  state <= ST_FIN;
        default: state <= ST_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_top.sv
// Bench for the NTT engine: reduced size (16 banks x 4 words), direct-evaluation reference model.
module tb_top;
  localparam int DW   = 32;
  localparam int BN   = 16;
  localparam int MA   = 4;
  localparam int N    = BN * MA;
  localparam int LOGN = 6;
  localparam logic [31:0] Q = 32'd167772161;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] modulus = Q;
  logic        DONE;

  top #(.D_width(DW), .BN(BN), .MA(MA)) dut (
    .clk(clk), .rst(rst), .modulus(modulus), .DONE(DONE)
  );

  always #5 clk = ~clk;

  logic [31:0] img  [0:N-1];
  logic [31:0] gold [0:N-1];
  logic [31:0] dump [0:N-1];
  logic [31:0] pw   [0:2*N-1];
  event        load_ev;
  int          nvec = 0, nerr = 0;
  int          rises = 0, wr_after = 0;
  logic        done_q = 1'b0;

  for (genvar g = 0; g < BN; g++) begin : bd
    always @(load_ev)
      for (int a = 0; a < MA; a++) dut.memory_wrapper.gen_sram[g].sram.mem[a] = img[a*BN+g];
    for (genvar a = 0; a < MA; a++) begin : ba
      assign dump[a*BN+g] = dut.memory_wrapper.gen_sram[g].sram.mem[a];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      rises    = 0;
      wr_after = 0;
    end else begin
      if (DONE && !done_q) rises++;
      if (DONE && dut.mem_we) wr_after++;
    end
    done_q = DONE;
  end

  function automatic logic [31:0] mulq(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    return 32'(p % {32'b0, Q});
  endfunction

  function automatic logic [31:0] powq(input logic [31:0] b, input int e);
    logic [31:0] r, x;
    r = 32'd1; x = b;
    for (int n = e; n > 0; n = n >> 1) begin
      if (n[0]) r = mulq(r, x);
      x = mulq(x, x);
    end
    return r;
  endfunction

  function automatic int brv(input int x);
    int r = 0;
    for (int b = 0; b < LOGN; b++) if (x[b]) r |= 1 << (LOGN - 1 - b);
    return r;
  endfunction

  // out[j] = sum_k a[k] * psi^((2*brv(j)+1)*k): the transform evaluated directly.
  task automatic build_gold();
    logic [31:0] acc;
    for (int jj = 0; jj < N; jj++) begin
      acc = 0;
      for (int kk = 0; kk < N; kk++)
        acc = (acc + mulq(img[kk], pw[((2*brv(jj)+1)*kk) % (2*N)])) % Q;
      gold[jj] = acc;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic load_all();
    for (int b = 0; b < 15; b++)
      dut.TF_top.TF_gen.TF_base_array[0][b] = (b < LOGN) ? pw[1 << b] : 32'd0;
    for (int r = 1; r < 5; r++)
      for (int b = 0; b < 15; b++) dut.TF_top.TF_gen.TF_base_array[r][b] = $urandom();
    for (int b = 0; b < 14; b++) dut.TF_top.TF_gen.TF_const_array[b] = $urandom();
    -> load_ev;
    #1;
  endtask

  task automatic start_run(input string tag);
    @(negedge clk);
    rst = 1'b0;
    load_all();
    repeat (2) @(negedge clk);
    check({tag, "_rst_done"}, {31'b0, DONE}, 32'd0);
    rst = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 20000 && !DONE; c++) @(negedge clk);
    check({tag, "_done"}, {31'b0, DONE}, 32'd1);
  endtask

  task automatic compare_all(input string tag, input longint exp_all);
    for (int jj = 0; jj < N; jj++)
      check($sformatf("%s_w%0d", tag, jj), dump[jj], (exp_all >= 0) ? 32'(exp_all) : gold[jj]);
  endtask

  typedef struct {
    int          kind;     // 0 zeros, 1 single nonzero at pos, 2 random
    int          pos;
    logic [31:0] val;
    longint      exp_all;  // every output word equals this, or -1 to use the model
  } vec_t;
  vec_t tbl [0:6];

  initial begin
    logic [31:0] psi;
    int drop;
    psi = powq(32'd3, int'((Q - 1) / (2 * N)));
    pw[0] = 32'd1;
    for (int e = 1; e < 2*N; e++) pw[e] = mulq(pw[e-1], psi);

    tbl = '{
      '{0, 0,     32'd0,   0},
      '{1, 0,     32'd1,   1},
      '{1, 0,     Q - 1,   longint'(Q - 1)},
      '{1, 1,     32'd1,   -1},
      '{1, N - 1, Q - 1,   -1},
      '{2, 0,     32'd0,   -1},
      '{2, 0,     32'd0,   -1}
    };

    for (int c = 0; c < 7; c++) begin
      string tag;
      tag = $sformatf("case%0d", c);
      for (int kk = 0; kk < N; kk++)
        img[kk] = (tbl[c].kind == 2) ? ($urandom() % Q) :
                  (tbl[c].kind == 1 && kk == tbl[c].pos) ? tbl[c].val : 32'd0;
      build_gold();
      start_run(tag);
      wait_done(tag);
      compare_all(tag, tbl[c].exp_all);
    end

    // Abort mid-transform, reload, rerun from scratch.
    for (int kk = 0; kk < N; kk++) img[kk] = $urandom() % Q;
    build_gold();
    start_run("abort");
    for (int c = 0; c < 20000 && dut.m != 6'd16; c++) @(negedge clk);
    check("abort_reach_stage", 32'(dut.m), 32'd16);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_done_low", {31'b0, DONE}, 32'd0);
    @(negedge clk);
    check("abort_done_low2", {31'b0, DONE}, 32'd0);
    load_all();
    @(negedge clk);
    rst = 1'b1;
    wait_done("rerun");
    compare_all("rerun", -1);

    // DONE holds, rises once, and the banks stay untouched.
    drop = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!DONE) drop++;
    end
    check("done_hold", 32'(drop), 32'd0);
    check("done_rises", 32'(rises), 32'd1);
    check("wr_after_done", 32'(wr_after), 32'd0);
    compare_all("post_hold", -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
